// File: rtl/fp_alu_arbiter_if.sv
// Bundle of the two requester channels, the shared-ALU port and the response
// channel of fp_alu_arbiter. The slave modport is the arbiter side.
interface fp_alu_arbiter_if;
  logic        req0_valid;
  logic        req0_ready;
  logic [2:0]  req0_op;
  logic [31:0] req0_a;
  logic [31:0] req0_b;
  logic        req1_valid;
  logic        req1_ready;
  logic [2:0]  req1_op;
  logic [31:0] req1_a;
  logic [31:0] req1_b;
  logic [31:0] alu_a;
  logic [31:0] alu_b;
  logic [2:0]  alu_sel;
  logic [31:0] alu_result;
  logic        alu_parity;
  logic        alu_overflow;
  logic        alu_underflow;
  logic        rsp_valid;
  logic        rsp_ready;
  logic        rsp_id;
  logic [31:0] rsp_result;
  logic        rsp_parity;
  logic        rsp_ovf;
  logic        rsp_unf;
  logic        rsp_err;
  logic        busy;

  modport slave (
    input  req0_valid, req0_op, req0_a, req0_b,
    input  req1_valid, req1_op, req1_a, req1_b,
    input  alu_result, alu_parity, alu_overflow, alu_underflow,
    input  rsp_ready,
    output req0_ready, req1_ready,
    output alu_a, alu_b, alu_sel,
    output rsp_valid, rsp_id, rsp_result, rsp_parity, rsp_ovf, rsp_unf, rsp_err,
    output busy
  );

  modport master (
    output req0_valid, req0_op, req0_a, req0_b,
    output req1_valid, req1_op, req1_a, req1_b,
    output alu_result, alu_parity, alu_overflow, alu_underflow,
    output rsp_ready,
    input  req0_ready, req1_ready,
    input  alu_a, alu_b, alu_sel,
    input  rsp_valid, rsp_id, rsp_result, rsp_parity, rsp_ovf, rsp_unf, rsp_err,
    input  busy
  );
endinterface

// File: rtl/fp_alu_arbiter.sv
// Round-robin arbiter sharing one combinational FP ALU between two requesters;
// holds operands for a per-op latency, then presents a registered response.
module fp_alu_arbiter #(
  parameter int LAT_ADD = 2,
  parameter int LAT_MUL = 3,
  parameter int LAT_DIV = 6,
  parameter int LAT_LOG = 1
) (
  input  logic              clk,
  input  logic              rst_n,
  fp_alu_arbiter_if.slave   bus
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    EXEC = 2'd1,
    RESP = 2'd2
  } state_e;

  state_e      state_r;
  logic [3:0]  cnt_r;
  logic        last_grant_r;
  logic        id_q_r;
  logic [31:0] alu_a_r;
  logic [31:0] alu_b_r;
  logic [2:0]  alu_sel_r;
  logic        rsp_valid_r;
  logic        rsp_id_r;
  logic [31:0] rsp_result_r;
  logic        rsp_parity_r;
  logic        rsp_ovf_r;
  logic        rsp_unf_r;
  logic        rsp_err_r;
  logic        busy_r;

  logic        grant_vld_s;
  logic        grant_id_s;
  logic        accept_s;
  logic [2:0]  sel_op_s;
  logic [31:0] sel_a_s;
  logic [31:0] sel_b_s;

  // Op 111 is the illegal encoding and completes in a single cycle.
  function automatic logic [3:0] lat_of(input logic [2:0] op);
    logic [3:0] lat_v;
    case (op)
      3'b000, 3'b001:         lat_v = 4'(LAT_ADD);
      3'b010:                 lat_v = 4'(LAT_MUL);
      3'b011:                 lat_v = 4'(LAT_DIV);
      3'b100, 3'b101, 3'b110: lat_v = 4'(LAT_LOG);
      default:                lat_v = 4'd1;
    endcase
    return lat_v;
  endfunction

  // Round-robin grant: on a tie the requester that did not win last time goes.
  always_comb begin
    grant_vld_s = 1'b0;
    grant_id_s  = 1'b0;
    if (bus.req0_valid && bus.req1_valid) begin
      grant_vld_s = 1'b1;
      grant_id_s  = ~last_grant_r;
    end else if (bus.req0_valid) begin
      grant_vld_s = 1'b1;
      grant_id_s  = 1'b0;
    end else if (bus.req1_valid) begin
      grant_vld_s = 1'b1;
      grant_id_s  = 1'b1;
    end else begin
      grant_vld_s = 1'b0;
      grant_id_s  = 1'b0;
    end
  end

  // Operand mux and handshake decode for the granted requester.
  always_comb begin
    accept_s = (state_r == IDLE) && grant_vld_s;
    if (grant_id_s) begin
      sel_op_s = bus.req1_op;
      sel_a_s  = bus.req1_a;
      sel_b_s  = bus.req1_b;
    end else begin
      sel_op_s = bus.req0_op;
      sel_a_s  = bus.req0_a;
      sel_b_s  = bus.req0_b;
    end
  end

  assign bus.req0_ready = accept_s && !grant_id_s;
  assign bus.req1_ready = accept_s && grant_id_s;

  // Control FSM with all datapath and response registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r      <= IDLE;
      cnt_r        <= 4'd0;
      last_grant_r <= 1'b1;
      id_q_r       <= 1'b0;
      alu_a_r      <= 32'd0;
      alu_b_r      <= 32'd0;
      alu_sel_r    <= 3'd0;
      rsp_valid_r  <= 1'b0;
      rsp_id_r     <= 1'b0;
      rsp_result_r <= 32'd0;
      rsp_parity_r <= 1'b0;
      rsp_ovf_r    <= 1'b0;
      rsp_unf_r    <= 1'b0;
      rsp_err_r    <= 1'b0;
      busy_r       <= 1'b0;
    end else begin
      case (state_r)
        IDLE: begin
          if (accept_s) begin
            alu_sel_r    <= sel_op_s;
            alu_a_r      <= sel_a_s;
            alu_b_r      <= sel_b_s;
            id_q_r       <= grant_id_s;
            last_grant_r <= grant_id_s;
            cnt_r        <= lat_of(sel_op_s) - 4'd1;
            busy_r       <= 1'b1;
            state_r      <= EXEC;
          end
        end
        EXEC: begin
          if (cnt_r == 4'd0) begin
            rsp_valid_r <= 1'b1;
            rsp_id_r    <= id_q_r;
            state_r     <= RESP;
            if (alu_sel_r == 3'b111) begin
              rsp_result_r <= 32'd0;
              rsp_parity_r <= 1'b0;
              rsp_ovf_r    <= 1'b0;
              rsp_unf_r    <= 1'b0;
              rsp_err_r    <= 1'b1;
            end else begin
              rsp_result_r <= bus.alu_result;
              rsp_parity_r <= bus.alu_parity;
              // Range flags only mean something for arithmetic ops.
              rsp_ovf_r    <= bus.alu_overflow & ~alu_sel_r[2];
              rsp_unf_r    <= bus.alu_underflow & ~alu_sel_r[2];
              rsp_err_r    <= 1'b0;
            end
          end else begin
            cnt_r <= cnt_r - 4'd1;
          end
        end
        RESP: begin
          if (bus.rsp_ready) begin
            rsp_valid_r <= 1'b0;
            busy_r      <= 1'b0;
            state_r     <= IDLE;
          end
        end
        default: begin
          rsp_valid_r <= 1'b0;
          busy_r      <= 1'b0;
          state_r     <= IDLE;
        end
      endcase
    end
  end

  assign bus.alu_a      = alu_a_r;
  assign bus.alu_b      = alu_b_r;
  assign bus.alu_sel    = alu_sel_r;
  assign bus.rsp_valid  = rsp_valid_r;
  assign bus.rsp_id     = rsp_id_r;
  assign bus.rsp_result = rsp_result_r;
  assign bus.rsp_parity = rsp_parity_r;
  assign bus.rsp_ovf    = rsp_ovf_r;
  assign bus.rsp_unf    = rsp_unf_r;
  assign bus.rsp_err    = rsp_err_r;
  assign bus.busy       = busy_r;

endmodule
